cic_rate_ctrl: RTL and testbench

- Sequencing and configuration controller for a CIC decimator instance. Sits between software/config logic and the decimator.
- Owns the decimator's `rate` and `rst` inputs and gates its output stream.
- Accepts rate-change requests and applies them only at a safe point: drain, flush the integrators/combs, then discard the settling outputs before resuming.
- Downstream consumers only ever see samples produced under a single, settled rate.

---
 rtl/cic_rate_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_cic_rate_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl: sequences rate changes for a CIC decimator (drain -> flush -> settle -> run).
// Define CIC_RATE_CTRL_STATS_EN to add the drop_cnt / flush_cnt statistics outputs.
module cic_rate_ctrl #(
    parameter int RMAX         = 64,
    parameter int N            = 2,
    parameter int DW           = 28,
    parameter int DEFAULT_RATE = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int DISCARD      = N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [$clog2(RMAX+1)-1:0] cfg_rate,
    input  logic                      cfg_rate_valid,
    output logic                      cfg_rate_ready,
    output logic                      dec_rst,
    output logic [$clog2(RMAX+1)-1:0] dec_rate,
    input  logic [DW-1:0]             dec_tdata,
    input  logic                      dec_tvalid,
    output logic                      dec_tready,
    output logic [DW-1:0]             m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      locked
`ifdef CIC_RATE_CTRL_STATS_EN
    ,
    output logic [15:0]               drop_cnt,
    output logic [7:0]                flush_cnt
`endif
);

    localparam int RW  = $clog2(RMAX + 1);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int DCW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

    localparam logic [FCW-1:0] FLUSH_LAST   = FCW'(FLUSH_CYCLES - 1);
    localparam logic [DCW-1:0] DISCARD_INIT = DCW'(DISCARD);
    localparam logic [DCW-1:0] DCNT_ONE     = DCW'(1);
    localparam logic [RW-1:0]  RATE_MAX     = RW'(RMAX);
    localparam logic [RW-1:0]  RATE_MIN     = RW'(1);
    localparam logic [RW-1:0]  RATE_DEF     = RW'(DEFAULT_RATE);

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0]  dec_rate_q, dec_rate_d;
    logic [RW-1:0]  pend_rate_q, pend_rate_d;
    logic [DW-1:0]  m_tdata_q, m_tdata_d;
    logic           m_tvalid_q, m_tvalid_d;

    logic           beat;
    logic           accept;
    logic           rate_diff;
    logic [RW-1:0]  req_clamped;

    assign beat      = dec_tvalid && dec_tready;
    assign accept    = cfg_rate_valid && cfg_rate_ready;
    assign rate_diff = (req_clamped != dec_rate_q);

    always_comb begin
        req_clamped = cfg_rate;
        if (cfg_rate == '0) begin
            req_clamped = RATE_MIN;
        end else if (cfg_rate > RATE_MAX) begin
            req_clamped = RATE_MAX;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FLUSH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; with DISCARD=0 the settle phase is skipped entirely
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FLUSH: begin
                if (fcnt_q == FLUSH_LAST) begin
                    state_d = (DISCARD == 0) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if ((dcnt_q == '0) || (beat && (dcnt_q == DCNT_ONE))) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && rate_diff) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!m_tvalid_q) begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    // Output decode
    always_comb begin
        dec_rst        = 1'b0;
        dec_tready     = 1'b0;
        cfg_rate_ready = 1'b0;
        locked         = 1'b0;
        unique case (state_q)
            ST_FLUSH:  dec_rst = 1'b1;
            ST_SETTLE: dec_tready = 1'b1;
            ST_RUN: begin
                dec_tready     = !m_tvalid_q || m_tready;
                cfg_rate_ready = 1'b1;
                locked         = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters, rate registers and the output stage
    always_comb begin
        fcnt_d      = fcnt_q;
        dcnt_d      = dcnt_q;
        dec_rate_d  = dec_rate_q;
        pend_rate_d = pend_rate_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;

        if (state_q == ST_FLUSH) begin
            fcnt_d = (fcnt_q == FLUSH_LAST) ? '0 : fcnt_q + 1'b1;
        end

        if ((state_q == ST_FLUSH) && (fcnt_q == FLUSH_LAST)) begin
            dcnt_d = DISCARD_INIT;
        end else if ((state_q == ST_SETTLE) && beat && (dcnt_q != '0)) begin
            dcnt_d = dcnt_q - 1'b1;
        end

        if ((state_q == ST_RUN) && accept && rate_diff) begin
            pend_rate_d = req_clamped;
        end

        // The new rate lands together with entry to FLUSH, so it only moves under dec_rst
        if ((state_q == ST_DRAIN) && !m_tvalid_q) begin
            dec_rate_d = pend_rate_q;
        end

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end
        if ((state_q == ST_RUN) && beat) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = dec_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            dec_rate_q  <= RATE_DEF;
            pend_rate_q <= RATE_DEF;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
        end else begin
            fcnt_q      <= fcnt_d;
            dcnt_q      <= dcnt_d;
            dec_rate_q  <= dec_rate_d;
            pend_rate_q <= pend_rate_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
        end
    end

    assign dec_rate = dec_rate_q;
    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;

`ifdef CIC_RATE_CTRL_STATS_EN
    logic [15:0] stat_drop_q, stat_drop_d;
    logic [7:0]  stat_flush_q, stat_flush_d;
    logic        rate_flush_q, rate_flush_d;

    // rate_flush marks a flush entered from DRAIN, which keeps the reset flush out of the count
    always_comb begin
        stat_drop_d  = stat_drop_q;
        stat_flush_d = stat_flush_q;
        rate_flush_d = rate_flush_q;
        if ((state_q == ST_SETTLE) && beat && (stat_drop_q != 16'hFFFF)) begin
            stat_drop_d = stat_drop_q + 16'd1;
        end
        if ((state_q == ST_DRAIN) && !m_tvalid_q) begin
            rate_flush_d = 1'b1;
        end
        if ((state_q == ST_FLUSH) && (fcnt_q == FLUSH_LAST)) begin
            rate_flush_d = 1'b0;
            if (rate_flush_q && (stat_flush_q != 8'hFF)) begin
                stat_flush_d = stat_flush_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_drop_q  <= '0;
            stat_flush_q <= '0;
            rate_flush_q <= 1'b0;
        end else begin
            stat_drop_q  <= stat_drop_d;
            stat_flush_q <= stat_flush_d;
            rate_flush_q <= rate_flush_d;
        end
    end

    assign drop_cnt  = stat_drop_q;
    assign flush_cnt = stat_flush_q;
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Testbench for cic_rate_ctrl: reset/settle vector table plus rate-change, clamp and
// mid-settle reset sequences, with a scoreboard on the decimator-to-output stream.
module tb_cic_rate_ctrl;

    localparam int RMAX         = 64;
    localparam int DW           = 28;
    localparam int RW           = 7;
    localparam int FLUSH_CYCLES = 2;
    localparam int DISCARD      = 2;
    localparam int NROWS        = 11;

    logic          clk;
    logic          rst_n;
    logic [RW-1:0] cfg_rate;
    logic          cfg_rate_valid;
    logic          cfg_rate_ready;
    logic          dec_rst;
    logic [RW-1:0] dec_rate;
    logic [DW-1:0] dec_tdata;
    logic          dec_tvalid;
    logic          dec_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          locked;
`ifdef CIC_RATE_CTRL_STATS_EN
    logic [15:0]   drop_cnt;
    logic [7:0]    flush_cnt;
`endif

    cic_rate_ctrl #(
        .RMAX(RMAX), .N(2), .DW(DW), .DEFAULT_RATE(64),
        .FLUSH_CYCLES(FLUSH_CYCLES), .DISCARD(DISCARD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_rate(cfg_rate), .cfg_rate_valid(cfg_rate_valid), .cfg_rate_ready(cfg_rate_ready),
        .dec_rst(dec_rst), .dec_rate(dec_rate),
        .dec_tdata(dec_tdata), .dec_tvalid(dec_tvalid), .dec_tready(dec_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .locked(locked)
`ifdef CIC_RATE_CTRL_STATS_EN
        , .drop_cnt(drop_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int drop_left = DISCARD;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor samples on the falling edge: handshakes seen here complete on the next rising edge
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [RW-1:0] prev_rate = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_rate = dec_rate;
        end else begin
            if (prev_hold) begin
                chk("stall_valid_held", m_tvalid, 1);
                chk("stall_data_held", m_tdata, prev_data);
            end
            if (dec_rate != prev_rate) chk("rate_moves_only_in_flush", dec_rst, 1);
            if (dec_tvalid && dec_tready) begin
                if (drop_left > 0) drop_left--;
                else exp_q.push_back(dec_tdata);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_output: got 0x%0h expected no beat", m_tdata);
                end else begin
                    chk("sb_data", m_tdata, exp_q.pop_front());
                end
            end
            prev_hold = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_rate = dec_rate;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          dv;
        logic [DW-1:0] dd;
        logic          mr;
        logic          e_rst;
        logic          e_trdy;
        logic          e_mv;
        logic          e_chk_d;
        logic [DW-1:0] e_md;
        logic          e_lock;
        logic          e_rdy;
    } vec_t;

    vec_t tbl[NROWS];

    task automatic init_table();
        //            dv    dd        mr    rst   trdy  mv    chkd  md        lock  rdy
        tbl[0]  = '{1'b0, 28'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 28'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 28'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 28'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 28'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'h00, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 28'h44, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 28'h33, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 28'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 28'h44, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 28'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 28'h44, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 28'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 28'h44, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 28'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 28'h55, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 28'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 28'h00, 1'b1, 1'b1};
    endtask

    // Releases reset and steps through the table, one row per clock
    task automatic run_table();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NROWS; i++) begin
            dec_tvalid = tbl[i].dv;
            dec_tdata  = tbl[i].dd;
            m_tready   = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("row%0d_dec_rst", i), dec_rst, tbl[i].e_rst);
            chk($sformatf("row%0d_dec_tready", i), dec_tready, tbl[i].e_trdy);
            chk($sformatf("row%0d_m_tvalid", i), m_tvalid, tbl[i].e_mv);
            if (tbl[i].e_chk_d) chk($sformatf("row%0d_m_tdata", i), m_tdata, tbl[i].e_md);
            chk($sformatf("row%0d_locked", i), locked, tbl[i].e_lock);
            chk($sformatf("row%0d_cfg_ready", i), cfg_rate_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d_dec_rate", i), dec_rate, 64);
            @(posedge clk);
            #1;
        end
        dec_tvalid = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [DW-1:0] d);
        int n = 0;
        dec_tdata  = d;
        dec_tvalid = 1'b1;
        @(negedge clk);
        while (!dec_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("beat_accept_timeout", dec_tready, 1);
        @(posedge clk);
        #1;
        dec_tvalid = 1'b0;
    endtask

    task automatic send_req(input logic [RW-1:0] r, output int waited);
        cfg_rate       = r;
        cfg_rate_valid = 1'b1;
        waited         = 0;
        @(negedge clk);
        while (!cfg_rate_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("req_accept_timeout", cfg_rate_ready, 1);
        @(posedge clk);
        #1;
        cfg_rate_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", (n < 100), 1);
    endtask

    // Full rate change: request, hold the pending output for `hold` cycles, flush, settle, resume
    task automatic rate_change(input logic [RW-1:0] req, input logic [RW-1:0] exp_rate,
                               input int hold);
        int w;
        int n;
        int hi;
        send_req(req, w);
        drop_left = DISCARD;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("drain_dec_tready", dec_tready, 0);
            chk("drain_dec_rst", dec_rst, 0);
            chk("drain_locked", locked, 0);
            chk("drain_m_tvalid", m_tvalid, 1);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!dec_rst && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("flush_seen", dec_rst, 1);
        chk("flush_dec_rate", dec_rate, exp_rate);
        chk("flush_dec_tready", dec_tready, 0);
        hi = 0;
        while (dec_rst && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        chk("flush_length", hi, FLUSH_CYCLES);
        @(posedge clk);
        #1;
        for (int i = 0; i < DISCARD; i++) begin
            @(negedge clk);
            chk("settle_locked", locked, 0);
            chk("settle_m_tvalid", m_tvalid, 0);
            @(posedge clk);
            #1;
            send_beat(28'hBAD0 + 28'(i));
        end
        @(negedge clk);
        chk("relock", locked, 1);
        chk("relock_rate", dec_rate, exp_rate);
        @(posedge clk);
        #1;
        send_beat(28'hC000 + 28'(exp_rate));
        wait_idle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w;
        int n;
        rst_n          = 1'b0;
        cfg_rate       = '0;
        cfg_rate_valid = 1'b0;
        dec_tdata      = '0;
        dec_tvalid     = 1'b0;
        m_tready       = 1'b0;
        init_table();
        repeat (3) @(posedge clk);

        run_table();

        // Same rate: accepted at once, no flush
        m_tready = 1'b1;
        send_req(7'd64, w);
        chk("same_rate_wait", w, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("same_rate_dec_rst", dec_rst, 0);
            chk("same_rate_locked", locked, 1);
            chk("same_rate_dec_rate", dec_rate, 64);
            @(posedge clk);
            #1;
        end

        // Rate 16 requested while an output is held by downstream
        m_tready = 1'b0;
        send_beat(28'h66);
        rate_change(7'd16, 7'd16, 3);

        // Clamping of out-of-range requests
        rate_change(7'd0, 7'd1, 0);
        rate_change(7'd100, 7'd64, 0);

        // Reset pulse in the middle of settling after a change to 16
        send_req(7'd16, w);
        drop_left = DISCARD;
        n = 0;
        @(negedge clk);
        while (!dec_rst && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (dec_rst && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("f_settle_tready", dec_tready, 1);
        chk("f_settle_locked", locked, 0);
        chk("f_settle_rate", dec_rate, 16);
        @(posedge clk);
        #1;
        cfg_rate       = 7'd8;
        cfg_rate_valid = 1'b1;
        @(negedge clk);
        chk("f_req_ignored_outside_run", cfg_rate_ready, 0);
        @(posedge clk);
        #1;
        cfg_rate_valid = 1'b0;
        send_beat(28'hAB);
        rst_n = 1'b0;
        #1;
        chk("async_rst_dec_rst", dec_rst, 1);
        chk("async_rst_dec_rate", dec_rate, 64);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_dec_tready", dec_tready, 0);
        chk("async_rst_cfg_ready", cfg_rate_ready, 0);
        chk("async_rst_m_tvalid", m_tvalid, 0);
        chk("async_rst_m_tdata", m_tdata, 0);
        drop_left = DISCARD;
        exp_q.delete();
        repeat (2) @(posedge clk);
        run_table();

        wait_idle();
        chk("sb_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
